// File: rtl/bayer_mosaicing_if.sv
// axi4_stream_if: AXI4-Stream signal bundle with master and slave views.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tid;
    logic                     tdest;
    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/bayer_mosaicing.sv
// bayer_mosaicing: keeps only the CFA colour at each pixel position of an RGB stream,
// producing a raw Bayer stream, and flags lines whose length differs from the frame's first line.
module bayer_mosaicing #(
    parameter int RAW_PX_WIDTH  = 10,
    parameter int MAX_LINE_SIZE = 1920
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [1:0]    pattern_i,
    axi4_stream_if.slave  rgb_video_i,
    axi4_stream_if.master raw_video_o,
    output logic          line_len_err_o
);
    localparam int RAW_TDATA_WIDTH = ((RAW_PX_WIDTH + 7) / 8) * 8;
    localparam int RGB_TDATA_WIDTH = ((3 * RAW_PX_WIDTH + 7) / 8) * 8;
    localparam int CW = $clog2(MAX_LINE_SIZE + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LINE_SIZE);

    logic                       w_ready, w_acc, w_sof, w_last, w_row, w_col, w_en;
    logic                       w_is_g, w_is_r, w_ref_vld, w_unused;
    logic [1:0]                 w_pat;
    logic [RGB_TDATA_WIDTH-1:0] w_rgb;
    logic [RAW_PX_WIDTH-1:0]    w_g, w_b, w_r, w_px;
    logic [CW-1:0]              w_base, w_cnt;
    logic                       r_row_odd, r_col_odd, r_en, r_ref_vld;
    logic [1:0]                 r_pattern;
    logic [CW-1:0]              r_cnt, r_ref;
    logic                       r_tvalid, r_tlast, r_tuser, r_err;
    logic [RAW_TDATA_WIDTH-1:0] r_tdata;

    assign w_ready = !r_tvalid || raw_video_o.tready;
    assign w_acc   = rgb_video_i.tvalid && w_ready;
    assign w_sof   = rgb_video_i.tuser[0];
    assign w_last  = rgb_video_i.tlast;
    assign w_rgb   = rgb_video_i.tdata;
    assign w_g     = w_rgb[RAW_PX_WIDTH-1:0];
    assign w_b     = w_rgb[2*RAW_PX_WIDTH-1:RAW_PX_WIDTH];
    assign w_r     = w_rgb[3*RAW_PX_WIDTH-1:2*RAW_PX_WIDTH];
    assign w_unused = ^{w_rgb, rgb_video_i.tkeep, rgb_video_i.tstrb, rgb_video_i.tid, rgb_video_i.tdest};

    // A start-of-frame beat is always (0,0) and uses the settings sampled on it.
    assign w_row = !w_sof && r_row_odd;
    assign w_col = !w_sof && r_col_odd;
    assign w_en  = w_sof ? en_i : r_en;
    assign w_pat = w_sof ? pattern_i : r_pattern;

    // pattern[0] set means green sits off the diagonal; pattern[1] picks the row that holds red.
    assign w_is_g = w_pat[0] ? (w_row ^ w_col) : !(w_row ^ w_col);
    assign w_is_r = w_row ^ w_pat[1];
    assign w_px   = (!w_en || w_is_g) ? w_g : (w_is_r ? w_r : w_b);

    assign w_ref_vld = !w_sof && r_ref_vld;
    assign w_base    = w_sof ? '0 : r_cnt;
    assign w_cnt     = (w_base == MAX_CNT) ? MAX_CNT : w_base + CW'(1);

    assign rgb_video_i.tready = w_ready;
    assign raw_video_o.tvalid = r_tvalid;
    assign raw_video_o.tdata  = r_tdata;
    assign raw_video_o.tlast  = r_tlast;
    assign raw_video_o.tuser  = r_tuser;
    assign raw_video_o.tkeep  = '1;
    assign raw_video_o.tstrb  = '1;
    assign raw_video_o.tid    = 1'b0;
    assign raw_video_o.tdest  = 1'b0;
    assign line_len_err_o     = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_tuser   <= 1'b0;
            r_err     <= 1'b0;
            r_row_odd <= 1'b0;
            r_col_odd <= 1'b0;
            r_en      <= 1'b0;
            r_pattern <= 2'b00;
            r_cnt     <= '0;
            r_ref     <= '0;
            r_ref_vld <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_ready) begin
                r_tvalid <= rgb_video_i.tvalid;
                r_tdata  <= RAW_TDATA_WIDTH'(w_px);
                r_tlast  <= w_last;
                r_tuser  <= w_sof;
            end
            if (w_acc) begin
                r_row_odd <= w_last ? !w_row : w_row;
                r_col_odd <= !w_last && !w_col;
                r_ref_vld <= w_last || w_ref_vld;
                if (w_sof) begin
                    r_en      <= en_i;
                    r_pattern <= pattern_i;
                end
                if (w_last) begin
                    r_cnt <= '0;
                    if (!w_ref_vld) r_ref <= w_cnt;
                    r_err <= w_ref_vld && (w_cnt != r_ref);
                end else begin
                    r_cnt <= w_cnt;
                    r_err <= (w_cnt == MAX_CNT) && (w_base != MAX_CNT);
                end
            end
        end
    end
endmodule

// File: tb/tb_bayer_mosaicing.sv
// tb_bayer_mosaicing: table-driven frames checked through an output scoreboard,
// plus stall, line-length and mid-frame reset sequences.
module tb_bayer_mosaicing;
    localparam logic [9:0] R = 10'h3FF;
    localparam logic [9:0] G = 10'h155;
    localparam logic [9:0] B = 10'h0AA;

    typedef struct {
        logic [1:0]      pat;
        logic            en;
        logic [7:0][9:0] px;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic en_i = 1'b0;
    logic [1:0] pattern_i = 2'b00;
    logic err;
    logic rnd = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    int last_tlast_cyc = -1;
    logic [17:0] q[$];
    logic prev_stall = 1'b0;
    logic [18:0] prev_out = '0;
    vec_t tbl [5];

    axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1)) rgb ();
    axi4_stream_if #(.TDATA_WIDTH(16), .TUSER_WIDTH(1)) raw ();

    bayer_mosaicing #(.RAW_PX_WIDTH(10), .MAX_LINE_SIZE(1920)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pattern_i(pattern_i),
        .rgb_video_i(rgb), .raw_video_o(raw), .line_len_err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0][9:0] px8(input logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7);
        px8 = {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    initial begin
        raw.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            raw.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_tready", {31'b0, rgb.tready}, {31'b0, !(raw.tvalid && !raw.tready)});
            if (prev_stall)
                chk("stall_hold", {13'b0, raw.tvalid, raw.tdata, raw.tlast, raw.tuser[0]}, {13'b0, prev_out});
            if (raw.tvalid && raw.tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h with nothing expected", raw.tdata);
                end else begin
                    chk("beat", {14'b0, raw.tdata, raw.tlast, raw.tuser[0]}, {14'b0, q.pop_front()});
                end
            end
            prev_stall = raw.tvalid && !raw.tready;
            prev_out = {raw.tvalid, raw.tdata, raw.tlast, raw.tuser[0]};
        end
        if (err) begin
            pulses++;
            pulse_cyc = cyc;
        end
    end

    // Drives one two-line frame; called and returns just after a rising edge.
    task automatic send_frame(input logic [1:0] pat, input logic en, input int n0, input int n1,
                              input logic [7:0][9:0] exp, input int sw_beat, input logic [1:0] sw_pat,
                              input int rst_beat);
        int b = 0;
        int n;
        int t;
        pattern_i = pat;
        en_i = en;
        for (int l = 0; l < 2; l++) begin
            n = (l == 0) ? n0 : n1;
            for (int p = 0; p < n; p++) begin
                rgb.tvalid = 1'b1;
                rgb.tdata = {2'b00, R, B, G};
                rgb.tuser = (b == 0);
                rgb.tlast = (p == n - 1);
                if (b == rst_beat) begin
                    #1 rst_i = 1'b1;
                    #1;
                    chk("rst_tvalid", {31'b0, raw.tvalid}, 32'd0);
                    chk("rst_tdata", {16'b0, raw.tdata}, 32'd0);
                    chk("rst_flags", {30'b0, raw.tlast, raw.tuser[0]}, 32'd0);
                    chk("rst_err", {31'b0, err}, 32'd0);
                    q.delete();
                    rgb.tvalid = 1'b0;
                    rgb.tuser = 1'b0;
                    rgb.tlast = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst_i = 1'b0;
                    return;
                end
                t = 0;
                forever begin
                    @(negedge clk);
                    if (rgb.tready) break;
                    t++;
                    if (t > 100) break;
                end
                if (t > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: beat %0d not accepted within 100 cycles", b);
                end
                q.push_back({6'b0, exp[b], rgb.tlast, rgb.tuser[0]});
                if (rgb.tlast) last_tlast_cyc = cyc + 1;
                @(posedge clk);
                #1;
                if (b == sw_beat) pattern_i = sw_pat;
                b++;
            end
        end
        rgb.tvalid = 1'b0;
        rgb.tuser = 1'b0;
        rgb.tlast = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q.size() != 0 || raw.tvalid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(name, q.size(), 32'd0);
    endtask

    initial begin
        int p0;
        tbl[0] = '{2'b11, 1'b1, px8(R, G, R, G, G, B, G, B)};
        tbl[1] = '{2'b01, 1'b1, px8(B, G, B, G, G, R, G, R)};
        tbl[2] = '{2'b10, 1'b1, px8(G, R, G, R, B, G, B, G)};
        tbl[3] = '{2'b00, 1'b1, px8(G, B, G, B, R, G, R, G)};
        tbl[4] = '{2'b11, 1'b0, px8(G, G, G, G, G, G, G, G)};
        rgb.tvalid = 1'b0;
        rgb.tdata = '0;
        rgb.tuser = 1'b0;
        rgb.tlast = 1'b0;
        rgb.tkeep = '1;
        rgb.tstrb = '1;
        rgb.tid = 1'b0;
        rgb.tdest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid", {31'b0, raw.tvalid}, 32'd0);
        chk("reset_tdata", {16'b0, raw.tdata}, 32'd0);
        chk("reset_flags", {30'b0, raw.tlast, raw.tuser[0]}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("tkeep_tstrb", {28'b0, raw.tkeep, raw.tstrb}, 32'hF);
        chk("tid_tdest", {30'b0, raw.tid, raw.tdest}, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].pat, tbl[i].en, 4, 4, tbl[i].px, -1, 2'b00, -1);
            drain($sformatf("drain_tbl%0d", i));
        end
        chk("no_err_regular", pulses, 32'd0);

        send_frame(2'b11, 1'b1, 4, 4, tbl[0].px, 1, 2'b01, -1);
        send_frame(2'b01, 1'b1, 4, 4, tbl[1].px, -1, 2'b00, -1);
        drain("drain_switch");

        rnd = 1'b1;
        for (int i = 0; i < 4; i++) send_frame(tbl[i].pat, 1'b1, 4, 4, tbl[i].px, -1, 2'b00, -1);
        send_frame(2'b11, 1'b0, 4, 4, tbl[4].px, -1, 2'b00, -1);
        drain("drain_stall");
        rnd = 1'b0;
        @(posedge clk);
        #1;
        chk("no_err_stall", pulses, 32'd0);

        p0 = pulses;
        send_frame(2'b11, 1'b1, 4, 3, px8(R, G, R, G, G, B, G, G), -1, 2'b00, -1);
        drain("drain_len");
        chk("len_err_count", pulses - p0, 32'd1);
        chk("len_err_cycle", pulse_cyc, last_tlast_cyc);

        p0 = pulses;
        send_frame(2'b11, 1'b1, 4, 4, tbl[0].px, -1, 2'b00, 2);
        send_frame(2'b11, 1'b1, 4, 4, tbl[0].px, -1, 2'b00, -1);
        drain("drain_reset");
        chk("no_err_reset", pulses - p0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/bayer_mosaicing.md
# bayer_mosaicing

Converts an RGB AXI4-Stream video stream into a single-channel raw Bayer stream, which is the inverse of the demosaicing stage. For each pixel it keeps only the colour component the selected CFA pattern places at that pixel's position. The block sits in test/loopback paths, for example:

- RGB test-pattern generator → bayer_mosaicing → raw processing chain.

It is also used to build sensor-like stimulus for the demosaicing pipeline.

## Interface
Parameters:
- RAW_PX_WIDTH, 10: bits per colour component and per raw pixel.
- MAX_LINE_SIZE, 1920: maximum pixels per line; sizes the line-length counter.
- RAW_TDATA_WIDTH, derived: RAW_PX_WIDTH rounded up to a multiple of 8.
- RGB_TDATA_WIDTH, derived: 3*RAW_PX_WIDTH rounded up to a multiple of 8.

Ports:
- clk_i  in  1  single clock; all logic is synchronous to it.
- rst_i  in  1  reset, asynchronous and active-high.
- en_i  in  1  mosaicing enable; sampled at frame start.
- pattern_i  in  2  CFA pattern, sampled at frame start: 00 GBRG, 01 BGGR, 10 GRBG, 11 RGGB.
- rgb_video_i  in  axi4_stream_if (RGB_TDATA_WIDTH, TUSER 1)  input stream.
  - tdata[W-1:0]=G, [2W-1:W]=B, [3W-1:2W]=R.
  - tuser = start of frame; tlast = end of line.
- raw_video_o  out  axi4_stream_if (RAW_TDATA_WIDTH, TUSER 1)  output stream.
  - Raw pixel is in tdata[W-1:0]; the upper pad bits are 0.
  - tkeep and tstrb are all 1s; tid and tdest are 0.
- line_len_err_o  out  1  one-cycle pulse on a line-length violation.

## Operation
- Position tracking uses two bits, row_odd and col_odd, which advance only on accepted input beats (tvalid && tready).
  - A tuser beat is treated as row 0, col 0.
  - After a tlast beat: col_odd=0 and row_odd toggles.
  - After any other beat: col_odd toggles.
- A tuser arriving mid-line resynchronises the position to (0,0); no error is raised for this.
- Frame-start sampling:
  - en_i and pattern_i are registered on the tuser beat, and that beat uses the newly sampled values.
  - Mid-frame changes of en_i or pattern_i have no effect until the next tuser.
  - Reset values of the sampled registers: en=0, pattern=00.
- Colour selection at (row_odd, col_odd) = (0,0),(0,1),(1,0),(1,1):
  - RGGB: R,G,G,B.
  - BGGR: B,G,G,R.
  - GRBG: G,R,B,G.
  - GBRG: G,B,R,G.
- With en=0 the output is the G component at every position (monochrome passthrough).
- tlast and tuser are forwarded unchanged, aligned with their pixel.
- Line-length check:
  - A pixel counter counts beats per line.
  - The first tlast after tuser records the frame's reference length.
  - line_len_err_o pulses on a later tlast beat whose count differs from the reference.
  - It also pulses when the count reaches MAX_LINE_SIZE without tlast; the counter saturates there.
  - The reference length is re-recorded every frame.
  - The output stream is never altered by this check.

## Timing
- Latency is one register stage: an input beat accepted at edge N appears on raw_video_o after edge N.
- rgb_video_i.tready = !raw_video_o.tvalid || raw_video_o.tready (combinational). This gives full throughput of one pixel per clock.
- Output registers load only when rgb_video_i.tready=1; raw_video_o.tvalid loads the input tvalid.
- While raw_video_o.tvalid=1 and tready=0, tdata, tlast and tuser hold stable.
- Reset values:
  - raw_video_o: tvalid=0, tdata=0, tlast=0, tuser=0.
  - line_len_err_o=0.
  - Position bits, pixel counter and reference-length-valid are cleared.
- Reset asserted mid-frame drops the in-flight beat. After release, output resumes only from the next accepted beat, and the position is taken as (0,0) until a tuser arrives.
- line_len_err_o asserts in the cycle after the offending beat is accepted.

## Test plan
Common setup: W=10, R=0x3FF, G=0x155, B=0x0AA for every pixel; 4x2 frame (4 pixels per line, 2 lines); raw_video_o.tready held 1 unless stated.
- Pattern RGGB, en=1:
  - Output is 3FF,155,3FF,155 then 155,0AA,155,0AA.
  - tuser is on the first beat only; tlast is on beats 4 and 8.
- All four patterns each produce their table order. en=0 produces 155 on every beat.
- pattern_i switched from RGGB to BGGR after beat 2:
  - The current frame stays RGGB.
  - The next frame starts 0AA,155,...
- raw_video_o.tready toggled pseudo-randomly at 50%:
  - No beat is lost or duplicated.
  - Output is held stable while stalled.
  - rgb_video_i.tready=0 exactly when the output is valid and stalled.
- Lines of 4 then 3 pixels:
  - line_len_err_o pulses once, one cycle after the second tlast.
  - Output data is still correct per position.
- rst_i asserted during beat 3:
  - Outputs go to 0 immediately.
  - After release, a new tuser frame produces correct RGGB output with no stale beat.
